// File: rtl/axi_beat_sequencer.sv
// ============================================================================
//  Module   : axi_beat_sequencer
//  Brief    : Round-robin AR/AW burst sequencer driving one shared beat channel
//  Revision : 1.0
// ============================================================================
`default_nettype none

module axi_beat_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int COUNT_W = 10,
  parameter int ID_W    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               rreq__ENA,
  input  logic [ADDR_W-1:0]  rreq_addr,
  input  logic [COUNT_W-1:0] rreq_count,
  input  logic [ID_W-1:0]    rreq_id,
  output logic               rreq__RDY,
  input  logic               wreq__ENA,
  input  logic [ADDR_W-1:0]  wreq_addr,
  input  logic [COUNT_W-1:0] wreq_count,
  input  logic [ID_W-1:0]    wreq_id,
  output logic               wreq__RDY,
  input  logic               wdata__ENA,
  input  logic [31:0]        wdata_data,
  output logic               wdata__RDY,
  output logic               beat__ENA,
  output logic               beat_write,
  output logic [ADDR_W-1:0]  beat_addr,
  output logic [ID_W-1:0]    beat_id,
  output logic               beat_first,
  output logic               beat_last,
  output logic [31:0]        beat_data,
  input  logic               beat__RDY,
  output logic               done__ENA,
  output logic [ID_W-1:0]    done_id,
  input  logic               done__RDY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RBURST = 2'd1,
    WBURST = 2'd2
  } state_t;

  localparam logic [COUNT_W-3:0] c_ONE_BEAT = 1;
  localparam logic [ADDR_W-1:0]  c_ADDR_INC = 1;

  state_t             r_state_q,     w_state_d;
  logic               r_last_wr_q,   w_last_wr_d;
  logic               r_done_pend_q, w_done_pend_d;
  logic [ID_W-1:0]    r_done_id_q,   w_done_id_d;
  logic [ADDR_W-1:0]  r_addr_q,      w_addr_d;
  logic [ID_W-1:0]    r_id_q,        w_id_d;
  logic [COUNT_W-3:0] r_rem_q,       w_rem_d;
  logic               r_first_q,     w_first_d;

  logic               w_wr_elig;
  logic               w_grant_rd;
  logic               w_grant_wr;
  logic               w_beat_fire;
  logic [COUNT_W-3:0] w_rd_beats;
  logic [COUNT_W-3:0] w_wr_beats;
  logic               w_unused_count_lsbs;

  // Sub-word byte counts are rounded down; a zero word count still moves one beat.
  assign w_rd_beats = (rreq_count[COUNT_W-1:2] == '0) ? c_ONE_BEAT : rreq_count[COUNT_W-1:2];
  assign w_wr_beats = (wreq_count[COUNT_W-1:2] == '0) ? c_ONE_BEAT : wreq_count[COUNT_W-1:2];
  assign w_unused_count_lsbs = ^{rreq_count[1:0], wreq_count[1:0]};

  assign w_wr_elig  = wreq__ENA & ~r_done_pend_q;
  assign w_grant_rd = rreq__ENA & (~w_wr_elig | r_last_wr_q);
  assign w_grant_wr = w_wr_elig & ~w_grant_rd;

  always_comb begin
    w_state_d     = r_state_q;
    w_last_wr_d   = r_last_wr_q;
    w_done_pend_d = r_done_pend_q;
    w_done_id_d   = r_done_id_q;
    w_addr_d      = r_addr_q;
    w_id_d        = r_id_q;
    w_rem_d       = r_rem_q;
    w_first_d     = r_first_q;
    w_beat_fire   = 1'b0;
    rreq__RDY     = 1'b0;
    wreq__RDY     = 1'b0;
    wdata__RDY    = 1'b0;
    beat__ENA     = 1'b0;
    beat_write    = 1'b0;
    beat_addr     = '0;
    beat_id       = '0;
    beat_first    = 1'b0;
    beat_last     = 1'b0;
    beat_data     = '0;
    done__ENA     = r_done_pend_q;
    done_id       = r_done_pend_q ? r_done_id_q : '0;

    if (r_done_pend_q && done__RDY) begin
      w_done_pend_d = 1'b0;
    end

    case (r_state_q)
      IDLE: begin
        rreq__RDY = w_grant_rd;
        wreq__RDY = w_grant_wr;
        if (w_grant_rd) begin
          w_addr_d    = rreq_addr;
          w_id_d      = rreq_id;
          w_rem_d     = w_rd_beats;
          w_first_d   = 1'b1;
          w_last_wr_d = 1'b0;
          w_state_d   = RBURST;
        end else if (w_grant_wr) begin
          w_addr_d    = wreq_addr;
          w_id_d      = wreq_id;
          w_rem_d     = w_wr_beats;
          w_first_d   = 1'b1;
          w_last_wr_d = 1'b1;
          w_state_d   = WBURST;
        end
      end
      RBURST: begin
        beat__ENA   = 1'b1;
        w_beat_fire = beat__RDY;
      end
      WBURST: begin
        beat__ENA   = wdata__ENA;
        beat_write  = 1'b1;
        beat_data   = wdata_data;
        wdata__RDY  = beat__RDY;
        w_beat_fire = wdata__ENA & beat__RDY;
      end
      default: w_state_d = IDLE;
    endcase

    if (r_state_q == RBURST || r_state_q == WBURST) begin
      beat_addr  = r_addr_q;
      beat_id    = r_id_q;
      beat_first = r_first_q;
      beat_last  = (r_rem_q == c_ONE_BEAT);
    end

    if (w_beat_fire) begin
      w_addr_d  = r_addr_q + c_ADDR_INC;
      w_rem_d   = r_rem_q - c_ONE_BEAT;
      w_first_d = 1'b0;
      if (r_rem_q == c_ONE_BEAT) begin
        w_state_d = IDLE;
        if (r_state_q == WBURST) begin
          w_done_pend_d = 1'b1;
          w_done_id_d   = r_id_q;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state_q     <= IDLE;
      r_last_wr_q   <= 1'b1;
      r_done_pend_q <= 1'b0;
      r_done_id_q   <= '0;
      r_addr_q      <= '0;
      r_id_q        <= '0;
      r_rem_q       <= '0;
      r_first_q     <= 1'b0;
    end else begin
      r_state_q     <= w_state_d;
      r_last_wr_q   <= w_last_wr_d;
      r_done_pend_q <= w_done_pend_d;
      r_done_id_q   <= w_done_id_d;
      r_addr_q      <= w_addr_d;
      r_id_q        <= w_id_d;
      r_rem_q       <= w_rem_d;
      r_first_q     <= w_first_d;
    end
  end

endmodule

`default_nettype wire
